// File: rtl/core_dispatch_arbiter_if.sv
// Bundle of handshake and data signals between the dispatch arbiter and its
// environment: event queue, per-core dispatch/return lines, core monitor.
interface core_dispatch_arbiter_if #(
    parameter int NUM_CORE  = 4,
    parameter int NB_COREID = $clog2(NUM_CORE),
    parameter int MSG_WID   = 32
);
    // Event queue side
    logic                        q_vld;
    logic [MSG_WID-1:0]          q_msg;
    logic                        q_deq;
    logic                        enq_full;
    logic                        enq_vld;
    logic [MSG_WID-1:0]          enq_msg;

    // Core side
    logic [NUM_CORE-1:0]         core_rdy;
    logic [NUM_CORE-1:0]         core_req;
    logic [NUM_CORE*MSG_WID-1:0] core_out_msg;
    logic [NUM_CORE-1:0]         core_ack;
    logic [NUM_CORE-1:0]         core_in_vld;
    logic [MSG_WID-1:0]          core_in_msg;
    logic [NUM_CORE-1:0]         core_active;

    // Core monitor side
    logic [MSG_WID-1:0]          mon_msg;
    logic                        mon_sent_vld;
    logic                        mon_rcv_vld;
    logic [NB_COREID-1:0]        mon_core_id;

    // Arbiter view
    modport master (
        input  q_vld, q_msg, enq_full, core_rdy, core_req, core_out_msg,
        output q_deq, enq_vld, enq_msg, core_ack, core_in_vld, core_in_msg,
               core_active, mon_msg, mon_sent_vld, mon_rcv_vld, mon_core_id
    );

    // Environment view
    modport slave (
        output q_vld, q_msg, enq_full, core_rdy, core_req, core_out_msg,
        input  q_deq, enq_vld, enq_msg, core_ack, core_in_vld, core_in_msg,
               core_active, mon_msg, mon_sent_vld, mon_rcv_vld, mon_core_id
    );
endinterface

// File: rtl/core_dispatch_arbiter.sv
// Dispatch arbiter: moves events from the queue head to idle cores (SEND) and
// returns finished events from cores back to the queue (RECV). One transaction
// at a time, followed by a settle window for the core monitor's pipeline.
// Returns have priority and are served round-robin; sends go to the
// lowest-index idle, inactive core.
module core_dispatch_arbiter #(
    parameter int NUM_CORE   = 4,
    parameter int NB_COREID  = $clog2(NUM_CORE),
    parameter int MSG_WID    = 32,
    parameter int SETTLE_CYC = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    core_dispatch_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_SEND,
        ST_SETTLE
    } state_t;

    localparam logic [3:0]          SETTLE_LOAD = 4'(SETTLE_CYC - 1);
    localparam logic [NUM_CORE-1:0] ONE_HOT0    = NUM_CORE'(1);

    // Control state
    state_t               r_state;
    logic [3:0]           r_settle_cnt;
    logic [NB_COREID-1:0] r_rr_ptr;
    logic [NB_COREID-1:0] r_sel;
    logic [NUM_CORE-1:0]  r_core_active;

    // Registered outputs
    logic                 r_q_deq;
    logic                 r_enq_vld;
    logic [MSG_WID-1:0]   r_enq_msg;
    logic [NUM_CORE-1:0]  r_core_ack;
    logic [NUM_CORE-1:0]  r_core_in_vld;
    logic [MSG_WID-1:0]   r_core_in_msg;
    logic [MSG_WID-1:0]   r_mon_msg;
    logic                 r_mon_sent_vld;
    logic                 r_mon_rcv_vld;
    logic [NB_COREID-1:0] r_mon_core_id;

    // Arbitration candidates
    logic [NUM_CORE-1:0]  w_rcv_mask;
    logic [NUM_CORE-1:0]  w_snd_mask;
    logic                 w_rcv_found;
    logic                 w_snd_found;
    logic [NB_COREID-1:0] w_rcv_idx;
    logic [NB_COREID-1:0] w_snd_idx;
    logic [NB_COREID-1:0] w_cand;
    logic [MSG_WID-1:0]   w_rcv_msg;

    // Only cores holding an event may return one; only idle, free cores may take one.
    assign w_rcv_mask  = bus.core_req & r_core_active;
    assign w_snd_mask  = bus.core_rdy & ~r_core_active;
    assign w_rcv_found = |w_rcv_mask;
    assign w_snd_found = |w_snd_mask;
    assign w_rcv_msg   = bus.core_out_msg[int'(w_rcv_idx) * MSG_WID +: MSG_WID];

    // Round-robin receive winner: first requester at or above rr_ptr, wrapping.
    // NOTE: every combinational output gets a default before the loop, so no latch is inferred.
    always_comb begin
        w_rcv_idx = '0;
        w_cand    = '0;
        // Scan downward so the last hit written is the nearest one to rr_ptr.
        for (int i = NUM_CORE - 1; i >= 0; i--) begin
            w_cand = r_rr_ptr + NB_COREID'(i);
            if (w_rcv_mask[w_cand]) w_rcv_idx = w_cand;
        end
    end

    // Send target: lowest-index idle, inactive core.
    always_comb begin
        w_snd_idx = '0;
        for (int i = NUM_CORE - 1; i >= 0; i--) begin
            if (w_snd_mask[i]) w_snd_idx = NB_COREID'(i);
        end
    end

    // Transaction FSM; every output is a register updated here.
    // NOTE: sequential state uses non-blocking assignments only, so all registers see pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_settle_cnt   <= '0;
            r_rr_ptr       <= '0;
            r_sel          <= '0;
            r_core_active  <= '0;
            r_q_deq        <= 1'b0;
            r_enq_vld      <= 1'b0;
            r_enq_msg      <= '0;
            r_core_ack     <= '0;
            r_core_in_vld  <= '0;
            r_core_in_msg  <= '0;
            r_mon_msg      <= '0;
            r_mon_sent_vld <= 1'b0;
            r_mon_rcv_vld  <= 1'b0;
            r_mon_core_id  <= '0;
        end else begin
            // Pulses and their payloads are only non-zero during RECV/SEND.
            r_q_deq        <= 1'b0;
            r_enq_vld      <= 1'b0;
            r_enq_msg      <= '0;
            r_core_ack     <= '0;
            r_core_in_vld  <= '0;
            r_core_in_msg  <= '0;
            r_mon_msg      <= '0;
            r_mon_sent_vld <= 1'b0;
            r_mon_rcv_vld  <= 1'b0;
            r_mon_core_id  <= '0;

            case (r_state)
                ST_IDLE: begin
                    if (w_rcv_found && !bus.enq_full) begin
                        r_state       <= ST_RECV;
                        r_sel         <= w_rcv_idx;
                        r_core_ack    <= ONE_HOT0 << w_rcv_idx;
                        r_enq_vld     <= 1'b1;
                        r_enq_msg     <= w_rcv_msg;
                        r_mon_msg     <= w_rcv_msg;
                        r_mon_rcv_vld <= 1'b1;
                        r_mon_core_id <= w_rcv_idx;
                    end else if (bus.q_vld && w_snd_found) begin
                        r_state        <= ST_SEND;
                        r_sel          <= w_snd_idx;
                        r_q_deq        <= 1'b1;
                        r_core_in_vld  <= ONE_HOT0 << w_snd_idx;
                        r_core_in_msg  <= bus.q_msg;
                        r_mon_msg      <= bus.q_msg;
                        r_mon_sent_vld <= 1'b1;
                        r_mon_core_id  <= w_snd_idx;
                    end
                end
                ST_RECV: begin
                    r_core_active[r_sel] <= 1'b0;
                    r_rr_ptr             <= r_sel + NB_COREID'(1);
                    r_settle_cnt         <= SETTLE_LOAD;
                    r_state              <= ST_SETTLE;
                end
                ST_SEND: begin
                    r_core_active[r_sel] <= 1'b1;
                    r_settle_cnt         <= SETTLE_LOAD;
                    r_state              <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (r_settle_cnt == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 4'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.q_deq        = r_q_deq;
    assign bus.enq_vld      = r_enq_vld;
    assign bus.enq_msg      = r_enq_msg;
    assign bus.core_ack     = r_core_ack;
    assign bus.core_in_vld  = r_core_in_vld;
    assign bus.core_in_msg  = r_core_in_msg;
    assign bus.core_active  = r_core_active;
    assign bus.mon_msg      = r_mon_msg;
    assign bus.mon_sent_vld = r_mon_sent_vld;
    assign bus.mon_rcv_vld  = r_mon_rcv_vld;
    assign bus.mon_core_id  = r_mon_core_id;

endmodule

// File: tb/tb_core_dispatch_arbiter.sv
// Bench for core_dispatch_arbiter: a transaction-level model predicts every
// cycle's outputs, directed scenarios pin concrete values, then random traffic.
module tb_core_dispatch_arbiter;

    localparam int NUM_CORE   = 4;
    localparam int NB_COREID  = 2;
    localparam int MSG_WID    = 32;
    localparam int SETTLE_CYC = 3;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   n_total = 0;
    int   n_bad   = 0;

    core_dispatch_arbiter_if #(
        .NUM_CORE (NUM_CORE),
        .NB_COREID(NB_COREID),
        .MSG_WID  (MSG_WID)
    ) bus ();

    core_dispatch_arbiter #(
        .NUM_CORE  (NUM_CORE),
        .NB_COREID (NB_COREID),
        .MSG_WID   (MSG_WID),
        .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_wait: edges until the arbiter looks at its inputs again (0 = this edge).
    // A transaction's effect on the active set becomes visible one edge later.
    int                  m_wait = 0;
    int                  m_rr = 0;
    logic [NUM_CORE-1:0] m_act = '0;
    int                  m_pend = 0;
    int                  m_pend_idx = 0;

    logic                 e_q_deq, e_enq_vld, e_sent, e_rcv;
    logic [MSG_WID-1:0]   e_enq_msg, e_in_msg, e_mon_msg;
    logic [NUM_CORE-1:0]  e_ack, e_in_vld, e_active;
    logic [NB_COREID-1:0] e_id;

    always @(posedge clk) begin
        int   win;
        int   snd;
        logic in_rst;
        in_rst    = !reset_n;
        e_q_deq   = 1'b0; e_enq_vld = 1'b0; e_sent = 1'b0; e_rcv = 1'b0;
        e_enq_msg = '0;   e_in_msg  = '0;   e_mon_msg = '0;
        e_ack     = '0;   e_in_vld  = '0;   e_id = '0;
        if (in_rst) begin
            m_wait = 0; m_rr = 0; m_act = '0; m_pend = 0;
            e_active = '0;
        end else begin
            if (m_pend == 1) m_act[m_pend_idx] = 1'b0;
            if (m_pend == 2) m_act[m_pend_idx] = 1'b1;
            m_pend   = 0;
            e_active = m_act;
            if (m_wait > 0) m_wait--;
            if (m_wait == 0) begin
                win = -1;
                if (!bus.enq_full) begin
                    for (int k = 0; k < NUM_CORE; k++) begin
                        if (win < 0 && bus.core_req[(m_rr + k) % NUM_CORE] && m_act[(m_rr + k) % NUM_CORE])
                            win = (m_rr + k) % NUM_CORE;
                    end
                end
                snd = -1;
                for (int c = NUM_CORE - 1; c >= 0; c--) begin
                    if (bus.core_rdy[c] && !m_act[c]) snd = c;
                end
                if (win >= 0) begin
                    e_rcv      = 1'b1;
                    e_enq_vld  = 1'b1;
                    e_ack[win] = 1'b1;
                    e_enq_msg  = bus.core_out_msg[win * MSG_WID +: MSG_WID];
                    e_mon_msg  = e_enq_msg;
                    e_id       = NB_COREID'(win);
                    m_rr       = (win + 1) % NUM_CORE;
                    m_pend     = 1; m_pend_idx = win;
                    m_wait     = SETTLE_CYC + 2;
                end else if (bus.q_vld && snd >= 0) begin
                    e_sent        = 1'b1;
                    e_q_deq       = 1'b1;
                    e_in_vld[snd] = 1'b1;
                    e_in_msg      = bus.q_msg;
                    e_mon_msg     = bus.q_msg;
                    e_id          = NB_COREID'(snd);
                    m_pend        = 2; m_pend_idx = snd;
                    m_wait        = SETTLE_CYC + 2;
                end
            end
        end
        #1;
        check("q_deq",        64'(bus.q_deq),        64'(e_q_deq));
        check("enq_vld",      64'(bus.enq_vld),      64'(e_enq_vld));
        check("core_ack",     64'(bus.core_ack),     64'(e_ack));
        check("core_in_vld",  64'(bus.core_in_vld),  64'(e_in_vld));
        check("mon_sent_vld", 64'(bus.mon_sent_vld), 64'(e_sent));
        check("mon_rcv_vld",  64'(bus.mon_rcv_vld),  64'(e_rcv));
        check("core_active",  64'(bus.core_active),  64'(e_active));
        if (in_rst || e_enq_vld) check("enq_msg", 64'(bus.enq_msg), 64'(e_enq_msg));
        if (in_rst || e_in_vld != '0) check("core_in_msg", 64'(bus.core_in_msg), 64'(e_in_msg));
        if (in_rst || e_sent || e_rcv) begin
            check("mon_msg",     64'(bus.mon_msg),     64'(e_mon_msg));
            check("mon_core_id", 64'(bus.mon_core_id), 64'(e_id));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_inputs();
        bus.q_vld        = 1'b0;
        bus.q_msg        = '0;
        bus.enq_full     = 1'b0;
        bus.core_rdy     = '0;
        bus.core_req     = '0;
        bus.core_out_msg = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Waits for a monitor pulse; returns the number of edges waited, -1 on timeout.
    task automatic wait_pulse(input bit rcv, input int max_cyc, input string name, output int cyc);
        cyc = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            @(posedge clk);
            #1;
            if ((rcv ? bus.mon_rcv_vld : bus.mon_sent_vld) === 1'b1) begin
                cyc = i;
                break;
            end
        end
        if (cyc < 0) begin
            n_total++;
            n_bad++;
            $display("FAIL %s: no pulse within %0d cycles", name, max_cyc);
        end
    endtask

    int cyc;
    int cnt;

    initial begin
        clear_inputs();

        // Reset state
        @(posedge clk);
        #1;
        check("rst_core_active", 64'(bus.core_active), 64'h0);
        check("rst_mon_core_id", 64'(bus.mon_core_id), 64'h0);
        check("rst_enq_msg",     64'(bus.enq_msg),     64'h0);

        // First send goes to core 0, the next one exactly 5 cycles later to core 1
        do_reset();
        bus.q_vld    = 1'b1;
        bus.q_msg    = 32'h0005_0010;
        bus.core_rdy = 4'b1111;
        wait_pulse(1'b0, 4, "s1_send0", cyc);
        check("s1_latency",     64'(cyc),             64'd1);
        check("s1_core_in_vld", 64'(bus.core_in_vld), 64'b0001);
        check("s1_core_in_msg", 64'(bus.core_in_msg), 64'h0005_0010);
        check("s1_q_deq",       64'(bus.q_deq),       64'd1);
        @(posedge clk);
        #1;
        check("s1_active",      64'(bus.core_active), 64'b0001);
        wait_pulse(1'b0, 10, "s1_send1", cyc);
        check("s1_spacing",     64'(cyc + 1),         64'd5);
        check("s1_core1",       64'(bus.core_in_vld), 64'b0010);

        // Round-robin returns from cores 1 and 2 starting at rr_ptr = 0
        do_reset();
        bus.q_vld    = 1'b1;
        bus.q_msg    = 32'h1234_0000;
        bus.core_rdy = 4'b0110;
        wait_pulse(1'b0, 4, "s2_send_a", cyc);
        wait_pulse(1'b0, 10, "s2_send_b", cyc);
        check("s2_send_b_id", 64'(bus.mon_core_id), 64'd2);
        @(negedge clk);
        bus.q_vld        = 1'b0;
        bus.core_req     = 4'b0110;
        bus.core_out_msg = {32'hDDDD_0003, 32'hB2B2_0002, 32'hA1A1_0001, 32'hCCCC_0000};
        wait_pulse(1'b1, 10, "s2_recv1", cyc);
        check("s2_recv1_id",  64'(bus.mon_core_id), 64'd1);
        check("s2_recv1_msg", 64'(bus.enq_msg),     64'hA1A1_0001);
        check("s2_recv1_ack", 64'(bus.core_ack),    64'b0010);
        wait_pulse(1'b1, 10, "s2_recv2", cyc);
        check("s2_recv2_id",  64'(bus.mon_core_id), 64'd2);
        check("s2_recv2_msg", 64'(bus.enq_msg),     64'hB2B2_0002);
        @(posedge clk);
        #1;
        check("s2_active",    64'(bus.core_active), 64'h0);

        // Receive beats a simultaneously eligible send
        do_reset();
        bus.q_vld    = 1'b1;
        bus.q_msg    = 32'h0000_0033;
        bus.core_rdy = 4'b1000;
        wait_pulse(1'b0, 4, "s3_send3", cyc);
        @(negedge clk);
        bus.q_vld = 1'b0;
        repeat (6) @(negedge clk);
        bus.core_req     = 4'b1000;
        bus.core_out_msg = {32'h3333_3333, 96'h0};
        bus.core_rdy     = 4'b0001;
        bus.q_vld        = 1'b1;
        wait_pulse(1'b1, 3, "s3_recv", cyc);
        check("s3_recv_first", 64'(cyc),              64'd1);
        check("s3_recv_id",    64'(bus.mon_core_id),  64'd3);
        check("s3_no_send",    64'(bus.mon_sent_vld), 64'd0);
        @(negedge clk);
        bus.core_req = '0;
        wait_pulse(1'b0, 10, "s3_send0", cyc);
        check("s3_send_id",    64'(bus.core_in_vld),  64'b0001);
        @(negedge clk);
        bus.q_vld = 1'b0;

        // enq_full blocks returns
        do_reset();
        bus.q_vld    = 1'b1;
        bus.core_rdy = 4'b0100;
        wait_pulse(1'b0, 4, "s4_send2", cyc);
        @(negedge clk);
        bus.q_vld    = 1'b0;
        bus.enq_full = 1'b1;
        bus.core_req = 4'b0100;
        cnt = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.core_ack != '0 || bus.enq_vld) cnt++;
        end
        check("s4_blocked", 64'(cnt), 64'd0);
        @(negedge clk);
        bus.enq_full = 1'b0;
        wait_pulse(1'b1, 2, "s4_recv2", cyc);
        check("s4_recv_id", 64'(bus.mon_core_id), 64'd2);
        @(negedge clk);
        bus.core_req = '0;

        // All cores busy: no dequeue until one returns
        do_reset();
        bus.q_vld    = 1'b1;
        bus.core_rdy = 4'b1111;
        for (int k = 0; k < NUM_CORE; k++) begin
            wait_pulse(1'b0, 10, "s5_fill", cyc);
            check("s5_fill_id", 64'(bus.mon_core_id), 64'(k));
        end
        @(posedge clk);
        #1;
        check("s5_all_active", 64'(bus.core_active), 64'b1111);
        cnt = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus.q_deq) cnt++;
        end
        check("s5_no_deq", 64'(cnt), 64'd0);
        @(negedge clk);
        bus.core_req = 4'b0100;
        wait_pulse(1'b1, 3, "s5_recv", cyc);
        check("s5_recv_id", 64'(bus.mon_core_id), 64'd2);
        @(negedge clk);
        bus.core_req = '0;
        wait_pulse(1'b0, 10, "s5_refill", cyc);
        check("s5_refill_id", 64'(bus.core_in_vld), 64'b0100);
        @(negedge clk);
        bus.q_vld = 1'b0;

        // Asynchronous reset in the middle of SETTLE
        do_reset();
        bus.q_vld    = 1'b1;
        bus.core_rdy = 4'b1011;
        repeat (3) wait_pulse(1'b0, 10, "s6_fill", cyc);
        @(negedge clk);
        bus.q_vld    = 1'b0;
        bus.core_req = 4'b1011;
        @(posedge clk);
        #1;
        check("s6_active_pre", 64'(bus.core_active), 64'b1011);
        #2;
        reset_n = 1'b0;
        #1;
        check("s6_rst_ctrl", 64'({bus.q_deq, bus.enq_vld, bus.mon_sent_vld, bus.mon_rcv_vld,
                                  bus.core_ack, bus.core_in_vld, bus.core_active}), 64'h0);
        check("s6_rst_data", 64'(bus.enq_msg | bus.core_in_msg | bus.mon_msg), 64'h0);
        check("s6_rst_id",   64'(bus.mon_core_id), 64'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bus.core_ack != '0) cnt++;
        end
        check("s6_req_ignored", 64'(cnt), 64'd0);

        // Random traffic with occasional asynchronous resets
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            bus.q_vld    = ($urandom_range(0, 9) < 7);
            bus.q_msg    = $urandom;
            bus.enq_full = ($urandom_range(0, 4) == 0);
            bus.core_rdy = NUM_CORE'($urandom);
            bus.core_req = NUM_CORE'($urandom);
            for (int p = 0; p < NUM_CORE; p++)
                bus.core_out_msg[p * MSG_WID +: MSG_WID] = $urandom;
            if ($urandom_range(0, 249) == 0) begin
                @(posedge clk);
                #3;
                reset_n = 1'b0;
                @(posedge clk);
                @(negedge clk);
                reset_n = 1'b1;
            end
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
